rf_wb_writer: RTL and testbench

Write-back arbiter that drives the register file's single write port (RFWr/A3/WD/inst). It merges the in-order pipeline's WB result with results from a long-latency side unit (multiplier/divider, load miss path), which are buffered in a small FIFO. It also keeps a pending-write scoreboard so the hazard unit can stall readers of registers whose side-unit result has not yet been written. Sits between the MEM/WB pipeline register, the multi-cycle unit, and RF.

---
 rtl/rf_wb_writer_pkg.sv | 11 +
 rtl/rf_wb_fifo.sv | 34 +++
 rtl/rf_wb_writer.sv | 80 ++++++++
 tb/tb_rf_wb_writer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_writer_pkg.sv
// rf_wb_writer_pkg: shared widths, write-source enum and side-result entry type for rf_wb_writer
package rf_wb_writer_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  typedef enum logic [1:0] {SRC_NONE, SRC_PIPE, SRC_FIFO, SRC_BYP} src_e;
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic [DW-1:0] inst;
  } wb_ent_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: DEPTH-entry sync FIFO of {rd, data, inst} side results
// Ports: clk, rst (async, active-high), push/din, pop/dout (head, valid when count>0), count.
// The caller guarantees push only when not full and pop only when not empty.
module rf_wb_fifo
  import rf_wb_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  wb_ent_t                  din,
  output wb_ent_t                  dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_ent_t mem [DEPTH];
  logic [PW-1:0] rp, wp;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/rf_wb_writer.sv
// rf_wb_writer: arbitrates the RF write port between pipeline WB and buffered side-unit results
// Ports: wb_* pipeline result (no backpressure); mc_issue/mc_issue_rd mark pending side writes;
// mc_valid/mc_ready/mc_* side-result handshake; RFWr/A3/WD/inst registered RF write;
// busy pending-write scoreboard; fifo_count entries held. clk, rst async active-high.
// Option: define RF_WB_BYPASS_EN to send a side result straight to the output register
// when the pipeline is idle and the FIFO is empty.
module rf_wb_writer
  import rf_wb_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_valid,
  input  logic [AW-1:0]          wb_rd,
  input  logic [DW-1:0]          wb_data,
  input  logic [DW-1:0]          wb_inst,
  input  logic                   mc_issue,
  input  logic [AW-1:0]          mc_issue_rd,
  input  logic                   mc_valid,
  output logic                   mc_ready,
  input  logic [AW-1:0]          mc_rd,
  input  logic [DW-1:0]          mc_data,
  input  logic [DW-1:0]          mc_inst,
  output logic                   RFWr,
  output logic [AW-1:0]          A3,
  output logic [DW-1:0]          WD,
  output logic [DW-1:0]          inst,
  output logic [31:0]            busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  wb_ent_t head, sel;
  src_e src;
  logic empty, accept, byp, push, pop;
  logic [31:0] set_m, clr_m;
  assign empty    = fifo_count == '0;
  assign mc_ready = !rst && fifo_count != CW'(DEPTH);
  assign accept   = mc_valid & mc_ready;
`ifdef RF_WB_BYPASS_EN
  assign byp = !wb_valid & empty & accept;
`else
  assign byp = 1'b0;
`endif
  assign pop  = !wb_valid & !empty;
  assign push = accept & !byp;
  always_comb begin
    src   = wb_valid ? SRC_PIPE : !empty ? SRC_FIFO : byp ? SRC_BYP : SRC_NONE;
    sel   = wb_valid ? wb_ent_t'({wb_rd, wb_data, wb_inst}) :
            !empty   ? head : wb_ent_t'({mc_rd, mc_data, mc_inst});
    clr_m = (src == SRC_FIFO || src == SRC_BYP) ? 32'(1) << sel.rd : '0;
    // applied after the clear so a same-cycle reissue stays pending
    set_m = (mc_issue && mc_issue_rd != '0) ? 32'(1) << mc_issue_rd : '0;
  end
  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({mc_rd, mc_data, mc_inst}),
    .dout  (head),
    .count (fifo_count)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      RFWr <= 1'b0;
      A3   <= '0;
      WD   <= '0;
      inst <= '0;
      busy <= '0;
    end else begin
      RFWr <= src != SRC_NONE && sel.rd != '0;
      if (src != SRC_NONE) begin
        A3   <= sel.rd;
        WD   <= sel.data;
        inst <= sel.inst;
      end
      busy <= ((busy & ~clr_m) | set_m) & ~32'h1;
    end
endmodule

// File: tb/tb_rf_wb_writer.sv
// tb_rf_wb_writer: randomized self-checking bench for rf_wb_writer against a queue-based model
module tb_rf_wb_writer;
  localparam int DEPTH = 4;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
    logic [31:0] i;
  } ent_t;

  logic clk = 1'b0, rst;
  logic wb_valid, mc_issue, mc_valid, mc_ready, RFWr;
  logic [4:0] wb_rd, mc_issue_rd, mc_rd, A3;
  logic [31:0] wb_data, wb_inst, mc_data, mc_inst, WD, inst, busy;
  logic [2:0] fifo_count;
  logic [105:0] obs_v, exp_v;

  ent_t q[$];
  logic e_wr;
  logic [4:0] e_a3;
  logic [31:0] e_wd, e_inst, e_busy;
  int n_chk = 0, n_fail = 0;

  rf_wb_writer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_inst(wb_inst),
    .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data), .mc_inst(mc_inst),
    .RFWr(RFWr), .A3(A3), .WD(WD), .inst(inst), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  assign obs_v = {RFWr, A3, WD, inst, busy, fifo_count, mc_ready};

  task automatic model_clear;
    q.delete();
    e_wr = 0; e_a3 = 0; e_wd = 0; e_inst = 0; e_busy = 0;
    exp_v = {e_wr, e_a3, e_wd, e_inst, e_busy, 3'(q.size()), 1'(q.size() < DEPTH)};
  endtask

  // Applies the write-back rules to the inputs currently driven, then advances one edge.
  task automatic tick;
    ent_t o;
    bit have, side, acc, by;
    acc = mc_valid && q.size() < DEPTH;
    have = 1; side = 0; by = 0;
    if (wb_valid) o = '{wb_rd, wb_data, wb_inst};
    else if (q.size() > 0) begin o = q.pop_front(); side = 1; end
    else if (BYP && acc) begin o = '{mc_rd, mc_data, mc_inst}; side = 1; by = 1; end
    else have = 0;
    if (acc && !by) q.push_back('{mc_rd, mc_data, mc_inst});
    if (side) e_busy[o.rd] = 1'b0;
    if (mc_issue && mc_issue_rd != 0) e_busy[mc_issue_rd] = 1'b1;
    e_busy[0] = 1'b0;
    e_wr = have && o.rd != 0;
    if (have) begin e_a3 = o.rd; e_wd = o.d; e_inst = o.i; end
    @(posedge clk); #1;
    exp_v = {e_wr, e_a3, e_wd, e_inst, e_busy, 3'(q.size()), 1'(q.size() < DEPTH)};
  endtask

  task automatic idle_inputs;
    wb_valid = 0; mc_issue = 0; mc_valid = 0;
    wb_rd = 0; wb_data = 0; wb_inst = 0; mc_issue_rd = 0; mc_rd = 0; mc_data = 0; mc_inst = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1;
    #1;
    n_chk++; if (obs_v !== '0) begin n_fail++; $display("FAIL reset_async: got %h expected 0", obs_v); end
    @(posedge clk); #1;
    n_chk++; if (obs_v !== '0) begin n_fail++; $display("FAIL reset_hold: got %h expected 0", obs_v); end
    rst = 0;
    model_clear();
    tick();
    n_chk++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_release: got %h expected %h", obs_v, exp_v); end
  endtask

  task automatic test_pipe;
    wb_valid = 1; wb_rd = 5; wb_data = 32'h1234; wb_inst = $urandom;
    tick();
    wb_valid = 0;
    n_chk++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL pipe_model: got %h expected %h", obs_v, exp_v); end
    n_chk++; if ({RFWr, A3, WD, busy} !== {1'b1, 5'd5, 32'h0000_1234, 32'h0})
      begin n_fail++; $display("FAIL pipe_write: got wr=%b a3=%0d wd=%h busy=%h expected 1 5 00001234 0", RFWr, A3, WD, busy); end
    tick();
    n_chk++; if (RFWr !== 1'b0) begin n_fail++; $display("FAIL pipe_idle: got RFWr=%b expected 0", RFWr); end
  endtask

  task automatic test_scoreboard;
    mc_issue = 1; mc_issue_rd = 7;
    tick();
    mc_issue = 0;
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (busy[7] !== 1'b1 || obs_v !== exp_v)
        begin n_fail++; $display("FAIL sb_pending c%0d: got %h expected %h", c, obs_v, exp_v); end
      tick();
    end
    mc_valid = 1; mc_rd = 7; mc_data = 32'hDEAD_BEEF; mc_inst = 32'h0220_0033;
    tick();
    mc_valid = 0;
    n_chk++; if ({RFWr, busy[7], fifo_count} !== {BYP, !BYP, BYP ? 3'd0 : 3'd1})
      begin n_fail++; $display("FAIL sb_edge1: got wr=%b busy7=%b cnt=%0d expected %b %b %0d", RFWr, busy[7], fifo_count, BYP, !BYP, BYP ? 0 : 1); end
    tick();
    n_chk++; if ({RFWr, A3, WD, busy[7]} !== {!BYP, 5'd7, 32'hDEAD_BEEF, 1'b0})
      begin n_fail++; $display("FAIL sb_edge2: got wr=%b a3=%0d wd=%h busy7=%b expected %b 7 deadbeef 0", RFWr, A3, WD, busy[7], !BYP); end
    n_chk++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL sb_model: got %h expected %h", obs_v, exp_v); end
  endtask

  task automatic test_back_to_back;
    int k = 0, n_acc = 0, nxt = 0;
    bit acc;
    for (int c = 0; c < 6; c++) begin
      wb_valid = 1; wb_rd = 5'($urandom_range(1, 9)); wb_data = $urandom; wb_inst = $urandom;
      mc_valid = k < 5; mc_rd = 5'(10 + k); mc_data = 32'(k); mc_inst = $urandom;
      acc = mc_valid && mc_ready;
      tick();
      if (acc) begin k++; n_acc++; end
      n_chk++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL b2b_fill c%0d: got %h expected %h", c, obs_v, exp_v); end
    end
    n_chk++; if (n_acc !== 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 4", n_acc); end
    wb_valid = 0;
    for (int c = 0; c < 12; c++) begin
      mc_valid = k < 5; mc_rd = 5'(10 + k); mc_data = 32'(k);
      acc = mc_valid && mc_ready;
      tick();
      if (acc) k++;
      n_chk++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL b2b_drain c%0d: got %h expected %h", c, obs_v, exp_v); end
      if (RFWr && A3 >= 10) begin
        n_chk++; if (A3 !== 5'(10 + nxt)) begin n_fail++; $display("FAIL b2b_order: got a3=%0d expected %0d", A3, 10 + nxt); end
        nxt++;
      end
    end
    mc_valid = 0;
    n_chk++; if (nxt !== 5) begin n_fail++; $display("FAIL b2b_writes: got %0d expected 5", nxt); end
  endtask

  task automatic test_wrap;
    int k = 100, nxt = 100;
    bit acc;
    for (int c = 0; c < 8 && q.size() < DEPTH; c++) begin
      wb_valid = 1; wb_rd = 5'($urandom_range(1, 15)); wb_data = $urandom;
      mc_valid = 1; mc_rd = 5'(16 + (k & 15)); mc_data = 32'(k); mc_inst = $urandom;
      acc = mc_valid && mc_ready;
      tick();
      if (acc) k++;
    end
    n_chk++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL wrap_full: got cnt=%0d expected 4", fifo_count); end
    wb_valid = 0;
    for (int c = 0; c < 10; c++) begin
      mc_valid = 1; mc_rd = 5'(16 + (k & 15)); mc_data = 32'(k); mc_inst = $urandom;
      acc = mc_valid && mc_ready;
      tick();
      if (acc) k++;
      n_chk++; if (obs_v !== exp_v || fifo_count !== 3'd3)
        begin n_fail++; $display("FAIL wrap_stream c%0d: got %h expected %h", c, obs_v, exp_v); end
      n_chk++; if (!RFWr || WD !== 32'(nxt))
        begin n_fail++; $display("FAIL wrap_order c%0d: got wr=%b wd=%0d expected 1 %0d", c, RFWr, WD, nxt); end
      nxt++;
    end
    mc_valid = 0;
    for (int c = 0; c < 8 && q.size() > 0; c++) tick();
  endtask

  task automatic test_rd0;
    mc_valid = 1; mc_rd = 0; mc_data = 32'hA5A5_0000; mc_inst = 32'h1357_9BDF;
    tick();
    mc_valid = 0;
    n_chk++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL rd0_edge1: got %h expected %h", obs_v, exp_v); end
    tick();
    n_chk++; if ({RFWr, A3, WD, inst, fifo_count} !== {1'b0, 5'd0, 32'hA5A5_0000, 32'h1357_9BDF, 3'd0})
      begin n_fail++; $display("FAIL rd0_pop: got wr=%b a3=%0d wd=%h inst=%h cnt=%0d expected 0 0 a5a50000 13579bdf 0", RFWr, A3, WD, inst, fifo_count); end
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      wb_valid = $urandom_range(0, 9) < 4; wb_rd = 5'($urandom); wb_data = $urandom; wb_inst = $urandom;
      mc_valid = $urandom_range(0, 1); mc_rd = 5'($urandom); mc_data = $urandom; mc_inst = $urandom;
      mc_issue = $urandom_range(0, 3) == 0; mc_issue_rd = 5'($urandom);
      tick();
      n_chk++; if (obs_v !== exp_v) begin n_fail++; $display("FAIL random c%0d: got %h expected %h", c, obs_v, exp_v); end
    end
    idle_inputs();
    for (int c = 0; c < 8 && q.size() > 0; c++) tick();
  endtask

  task automatic test_reset_mid;
    int k = 0;
    bit acc;
    mc_issue = 1; mc_issue_rd = 9;
    tick();
    mc_issue = 0;
    for (int c = 0; c < 8 && k < 3; c++) begin
      wb_valid = 1; wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
      mc_valid = 1; mc_rd = 5'(20 + k); mc_data = $urandom;
      acc = mc_valid && mc_ready;
      tick();
      if (acc) k++;
    end
    n_chk++; if (fifo_count !== 3'd3 || busy[9] !== 1'b1)
      begin n_fail++; $display("FAIL rmid_setup: got cnt=%0d busy9=%b expected 3 1", fifo_count, busy[9]); end
    #2 rst = 1;
    #1;
    n_chk++; if (obs_v !== '0) begin n_fail++; $display("FAIL rmid_async: got %h expected 0", obs_v); end
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    for (int c = 0; c < 4; c++) begin
      tick();
      n_chk++; if (RFWr !== 1'b0 || obs_v !== exp_v)
        begin n_fail++; $display("FAIL rmid_after c%0d: got %h expected %h", c, obs_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_pipe();
    test_scoreboard();
    test_back_to_back();
    test_wrap();
    test_rd0();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
